instruction_fetch: RTL

Instruction fetch stage that feeds `instruction_code` into the `processor` core. It holds the program counter and a word-addressed instruction memory with a program-load port. It delivers one registered instruction per cycle with a `valid` qualifier. It supports a downstream stall and a branch/jump redirect that flushes the in-flight slot.

---
 rtl/instruction_fetch.sv | 83 ++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: program counter, word-addressed instruction memory
// with a program-load port, and one registered instruction slot per cycle.
module instruction_fetch #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  output logic [31:0]       instruction_code,
  output logic [31:0]       pc_out,
  output logic              valid,
  output logic              fault
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       pc;
  logic [0:0]        state;
  logic [ADDR_W-1:0] fetch_idx;
  logic              misaligned;

  // PCs beyond the array alias modulo depth by dropping the upper bits.
  assign fetch_idx  = pc[ADDR_W+1:2];
  assign misaligned = redirect_pc[1:0] != 2'b00;
  assign fault      = state == ST_FAULT;

  // NOTE: the memory has no reset so it maps onto RAM; writes are accepted even
  // while reset is asserted, which is how programs are loaded.
  always_ff @(posedge clock) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // NOTE: non-blocking assignments give read-before-write on a same-word
  // write and fetch, since the read below sees the pre-edge memory contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc               <= RESET_PC;
      instruction_code <= NOP;
      pc_out           <= 32'h0;
      valid            <= 1'b0;
      state            <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (redirect && misaligned) begin
            state            <= ST_FAULT;
            valid            <= 1'b0;
            instruction_code <= NOP;
          end else if (redirect) begin
            // Redirect flushes the slot and wins over stall.
            pc               <= redirect_pc;
            valid            <= 1'b0;
            instruction_code <= NOP;
          end else if (!stall) begin
            instruction_code <= mem[fetch_idx];
            pc_out           <= pc;
            valid            <= 1'b1;
            pc               <= pc + 32'd4;
          end
        end
        default: begin
          // Absorbing: only reset leaves the fault state.
          valid            <= 1'b0;
          instruction_code <= NOP;
        end
      endcase
    end
  end

endmodule
